// File: rtl/sp_dma.sv
// sp_dma: single-channel block-copy DMA engine sharing the SP SRAM port with
// the CTL sequencer. A command (source, destination, word count) is copied one
// 32-bit word at a time: read the source word, capture it, write it to the
// destination. The engine only moves on READ/WRITE cycles in which the arbiter
// grants it the port.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   cmd_valid  command strobe (sampled only while idle)
//   cmd_ready  engine idle, command can be accepted
//   cmd_src    source word address
//   cmd_dst    destination word address
//   cmd_len    word count (0 is legal)
//   abort      synchronous cancel back to idle
//   busy       engine not idle
//   remaining  words not yet written
//   done       one-cycle completion pulse
//   mem_req    engine requests the SRAM port
//   mem_gnt    arbiter grant, same cycle as mem_req
//   dma_ADDR   SRAM address (0 when not requesting)
//   dma_DI     SRAM write data (0 when not requesting)
//   dma_WE     SRAM write enable
//   sram_DO    SRAM read data, one cycle after the address
module sp_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_src,
  input  logic [15:0] cmd_dst,
  input  logic [15:0] cmd_len,
  input  logic        abort,
  output logic        busy,
  output logic [15:0] remaining,
  output logic        done,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [15:0] dma_ADDR,
  output logic [31:0] dma_DI,
  output logic        dma_WE,
  input  logic [31:0] sram_DO
);

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_RDWAIT = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   src_addr, src_addr_nxt;
  logic [ADDR_W-1:0]   dst_addr, dst_addr_nxt;
  logic [ADDR_W-1:0]   remaining_nxt;
  logic [DATA_W-1:0]   data_buf, data_buf_nxt;
  logic                wr_fire;

  // A write only happens when granted and not cancelled in the same cycle.
  assign wr_fire = (state == S_WRITE) && mem_gnt && !abort;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      src_addr  <= '0;
      dst_addr  <= '0;
      remaining <= '0;
      data_buf  <= '0;
    end else begin
      state     <= state_nxt;
      src_addr  <= src_addr_nxt;
      dst_addr  <= dst_addr_nxt;
      remaining <= remaining_nxt;
      data_buf  <= data_buf_nxt;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_nxt     = state;
    src_addr_nxt  = src_addr;
    dst_addr_nxt  = dst_addr;
    remaining_nxt = remaining;
    data_buf_nxt  = data_buf;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid && !abort) begin
          src_addr_nxt  = cmd_src;
          dst_addr_nxt  = cmd_dst;
          remaining_nxt = cmd_len;
          state_nxt     = (cmd_len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (abort)        state_nxt = S_IDLE;
        else if (mem_gnt) state_nxt = S_RDWAIT;
      end
      S_RDWAIT: begin
        data_buf_nxt = sram_DO;
        state_nxt    = abort ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (mem_gnt) begin
          // Address increments wrap silently at the top of the 16-bit space.
          src_addr_nxt  = src_addr + 16'd1;
          dst_addr_nxt  = dst_addr + 16'd1;
          remaining_nxt = remaining - 16'd1;
          state_nxt     = (remaining == 16'd1) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // SRAM-side outputs are purely combinational; address and data are forced
  // to zero whenever the port is not requested.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    mem_req   = 1'b0;
    dma_ADDR  = '0;
    dma_DI    = '0;
    dma_WE    = 1'b0;
    if (state == S_READ) begin
      mem_req  = 1'b1;
      dma_ADDR = src_addr;
    end else if (state == S_WRITE) begin
      mem_req  = 1'b1;
      dma_ADDR = dst_addr;
      dma_DI   = data_buf;
      dma_WE   = wr_fire;
    end
  end

endmodule

// File: tb/tb_sp_dma.sv
module tb_sp_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_src = '0;
  logic [15:0] cmd_dst = '0;
  logic [15:0] cmd_len = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic [15:0] remaining;
  logic        done;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [15:0] dma_ADDR;
  logic [31:0] dma_DI;
  logic        dma_WE;
  logic [31:0] sram_DO = '0;

  always #5 clk = ~clk;

  sp_dma dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .abort(abort), .busy(busy), .remaining(remaining), .done(done),
    .mem_req(mem_req), .mem_gnt(mem_gnt),
    .dma_ADDR(dma_ADDR), .dma_DI(dma_DI), .dma_WE(dma_WE),
    .sram_DO(sram_DO)
  );

  // SRAM model and expected-memory reference
  logic [31:0] mem     [0:65535];
  logic [31:0] exp_mem [0:65535];
  bit          mem_init = 1'b0;
  logic        ld_we = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  function automatic logic [31:0] seed_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= seed_word(i);
      mem_init <= 1'b1;
    end else begin
      if (dma_WE) mem[dma_ADDR] <= dma_DI;
      if (ld_we)  mem[ld_addr]  <= ld_data;
    end
    sram_DO <= mem[dma_ADDR];
  end

  int n_checks = 0;
  int n_errors = 0;

  // Observations collected by the command driver
  logic [15:0] rd_q[$];
  logic [15:0] wr_q[$];
  logic [31:0] wd_q[$];
  logic [15:0] rem_q[$];
  int done_cyc, n_done, stall_cnt, we_bad, we_abort, idle_cyc;
  bit req_seen;
  bit gpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Forward word-by-word copy in ascending order (reference behaviour).
  task automatic ref_copy(input logic [15:0] s, input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) exp_mem[16'(d + i)] = exp_mem[16'(s + i)];
  endtask

  task automatic load_word(input logic [15:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    ld_we = 1'b1; ld_addr = a; ld_data = v;
    @(posedge clk); #1;
    ld_we = 1'b0;
    exp_mem[a] = v;
  endtask

  // Issue one command and observe every cycle until the engine is idle again.
  // gmode: 0 grant always, 1 repeating 1-0-0-1 grant pattern, 2 random grant.
  task automatic run_cmd(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                         input int gmode, input int abort_cyc, input int max_cyc);
    rd_q.delete(); wr_q.delete(); wd_q.delete(); rem_q.delete();
    done_cyc = 0; n_done = 0; stall_cnt = 0; we_bad = 0; we_abort = 0;
    idle_cyc = 0; req_seen = 1'b0;
    @(posedge clk); #1;
    cmd_src = s; cmd_dst = d; cmd_len = l; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      case (gmode)
        0:       mem_gnt = 1'b1;
        1:       mem_gnt = gpat[(c - 1) % 4];
        default: mem_gnt = ($urandom_range(0, 3) != 0);
      endcase
      abort = (c == abort_cyc);
      @(negedge clk);
      rem_q.push_back(remaining);
      if (mem_req) req_seen = 1'b1;
      if (mem_req && !mem_gnt) stall_cnt++;
      if (dma_WE && !mem_gnt) we_bad++;
      if (dma_WE && abort) we_abort++;
      if (mem_req && mem_gnt && dma_WE) begin
        wr_q.push_back(dma_ADDR);
        wd_q.push_back(dma_DI);
      end else if (mem_req && mem_gnt && !abort) begin
        rd_q.push_back(dma_ADDR);
      end
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (cmd_ready) begin
        idle_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rst_cmd_ready: got %b, want 1", cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b, want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b, want 0", done); end
    n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL rst_mem_req: got %b, want 0", mem_req); end
    n_checks++; if (dma_WE !== 1'b0) begin n_errors++; $display("FAIL rst_we: got %b, want 0", dma_WE); end
    n_checks++; if (dma_ADDR !== 16'h0) begin n_errors++; $display("FAIL rst_addr: got %h, want 0000", dma_ADDR); end
    n_checks++; if (dma_DI !== 32'h0) begin n_errors++; $display("FAIL rst_di: got %h, want 0", dma_DI); end
    n_checks++; if (remaining !== 16'h0) begin n_errors++; $display("FAIL rst_remaining: got %h, want 0000", remaining); end
    #1 reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rst_release_ready: got %b, want 1", cmd_ready); end
  endtask

  task automatic test_basic_copy();
    for (int i = 0; i < 4; i++) load_word(16'(16'h10 + i), 32'hA000_0000 | 32'(i));
    ref_copy(16'h10, 16'h40, 4);
    run_cmd(16'h10, 16'h40, 16'd4, 0, 0, 100);
    n_checks++; if (done_cyc !== 13) begin n_errors++; $display("FAIL basic_done_cycle: got %0d, want 13", done_cyc); end
    n_checks++; if (n_done !== 1) begin n_errors++; $display("FAIL basic_done_count: got %0d, want 1", n_done); end
    n_checks++; if (idle_cyc !== 14) begin n_errors++; $display("FAIL basic_idle_cycle: got %0d, want 14", idle_cyc); end
    n_checks++; if (we_bad !== 0) begin n_errors++; $display("FAIL basic_we_without_gnt: got %0d, want 0", we_bad); end
    for (int i = 0; i < 13; i++) begin
      logic [15:0] want, got;
      want = 16'(4 - i / 3);
      got = (rem_q.size() > i) ? rem_q[i] : 16'hFFFF;
      n_checks++; if (got !== want) begin n_errors++; $display("FAIL basic_remaining cycle %0d: got %0d, want %0d", i + 1, got, want); end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (mem[16'h40 + i] !== (32'hA000_0000 | 32'(i))) begin n_errors++; $display("FAIL basic_dst[%0d]: got %h, want %h", i, mem[16'h40 + i], 32'hA000_0000 | 32'(i)); end
      n_checks++; if (mem[16'h10 + i] !== (32'hA000_0000 | 32'(i))) begin n_errors++; $display("FAIL basic_src[%0d]: got %h, want %h", i, mem[16'h10 + i], 32'hA000_0000 | 32'(i)); end
    end
    n_checks++; if (mem[16'h44] !== exp_mem[16'h44]) begin n_errors++; $display("FAIL basic_overrun: got %h, want %h", mem[16'h44], exp_mem[16'h44]); end
  endtask

  task automatic test_zero_len();
    run_cmd(16'h20, 16'h30, 16'd0, 0, 0, 20);
    n_checks++; if (req_seen !== 1'b0) begin n_errors++; $display("FAIL zero_mem_req: got %b, want 0", req_seen); end
    n_checks++; if (done_cyc !== 1) begin n_errors++; $display("FAIL zero_done_cycle: got %0d, want 1", done_cyc); end
    n_checks++; if (idle_cyc !== 2) begin n_errors++; $display("FAIL zero_idle_cycle: got %0d, want 2", idle_cyc); end
    n_checks++; if (n_done !== 1) begin n_errors++; $display("FAIL zero_done_count: got %0d, want 1", n_done); end
    n_checks++; if (mem[16'h30] !== exp_mem[16'h30]) begin n_errors++; $display("FAIL zero_dst: got %h, want %h", mem[16'h30], exp_mem[16'h30]); end
  endtask

  task automatic test_grant_stalls();
    ref_copy(16'h200, 16'h300, 2);
    run_cmd(16'h200, 16'h300, 16'd2, 1, 0, 50);
    n_checks++; if (stall_cnt !== 2) begin n_errors++; $display("FAIL stall_count: got %0d, want 2", stall_cnt); end
    n_checks++; if (done_cyc !== 7 + stall_cnt) begin n_errors++; $display("FAIL stall_done_cycle: got %0d, want %0d", done_cyc, 7 + stall_cnt); end
    n_checks++; if (idle_cyc !== 10) begin n_errors++; $display("FAIL stall_idle_cycle: got %0d, want 10", idle_cyc); end
    n_checks++; if (we_bad !== 0) begin n_errors++; $display("FAIL stall_we_without_gnt: got %0d, want 0", we_bad); end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (mem[16'h300 + i] !== exp_mem[16'h300 + i]) begin n_errors++; $display("FAIL stall_dst[%0d]: got %h, want %h", i, mem[16'h300 + i], exp_mem[16'h300 + i]); end
    end
  endtask

  task automatic test_address_wrap();
    logic [15:0] rd_exp [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    ref_copy(16'hFFFE, 16'h0100, 3);
    run_cmd(16'hFFFE, 16'h0100, 16'd3, 0, 0, 100);
    n_checks++; if (rd_q.size() !== 3) begin n_errors++; $display("FAIL wrap_read_count: got %0d, want 3", rd_q.size()); end
    n_checks++; if (wr_q.size() !== 3) begin n_errors++; $display("FAIL wrap_write_count: got %0d, want 3", wr_q.size()); end
    n_checks++; if (done_cyc !== 10) begin n_errors++; $display("FAIL wrap_done_cycle: got %0d, want 10", done_cyc); end
    for (int i = 0; i < 3; i++) begin
      logic [15:0] ra, wa;
      ra = (rd_q.size() > i) ? rd_q[i] : 16'h1234;
      wa = (wr_q.size() > i) ? wr_q[i] : 16'h1234;
      n_checks++; if (ra !== rd_exp[i]) begin n_errors++; $display("FAIL wrap_read_addr[%0d]: got %h, want %h", i, ra, rd_exp[i]); end
      n_checks++; if (wa !== 16'(16'h0100 + i)) begin n_errors++; $display("FAIL wrap_write_addr[%0d]: got %h, want %h", i, wa, 16'(16'h0100 + i)); end
      n_checks++; if (mem[16'h0100 + i] !== exp_mem[16'h0100 + i]) begin n_errors++; $display("FAIL wrap_dst[%0d]: got %h, want %h", i, mem[16'h0100 + i], exp_mem[16'h0100 + i]); end
    end
  endtask

  task automatic test_abort_write();
    logic [15:0] w0, rlast;
    ref_copy(16'h500, 16'h600, 1);
    // With grant held high the second WRITE falls in cycle 6.
    run_cmd(16'h500, 16'h600, 16'd4, 0, 6, 50);
    w0 = (wr_q.size() > 0) ? wr_q[0] : 16'hFFFF;
    rlast = (rem_q.size() > 0) ? rem_q[rem_q.size() - 1] : 16'hFFFF;
    n_checks++; if (we_abort !== 0) begin n_errors++; $display("FAIL abort_we: got %0d, want 0", we_abort); end
    n_checks++; if (wr_q.size() !== 1) begin n_errors++; $display("FAIL abort_write_count: got %0d, want 1", wr_q.size()); end
    n_checks++; if (w0 !== 16'h600) begin n_errors++; $display("FAIL abort_write_addr: got %h, want 0600", w0); end
    n_checks++; if (n_done !== 0) begin n_errors++; $display("FAIL abort_done: got %0d, want 0", n_done); end
    n_checks++; if (idle_cyc !== 7) begin n_errors++; $display("FAIL abort_idle_cycle: got %0d, want 7", idle_cyc); end
    n_checks++; if (rlast !== 16'd3) begin n_errors++; $display("FAIL abort_remaining: got %0d, want 3", rlast); end
    n_checks++; if (mem[16'h600] !== exp_mem[16'h600]) begin n_errors++; $display("FAIL abort_dst0: got %h, want %h", mem[16'h600], exp_mem[16'h600]); end
    n_checks++; if (mem[16'h601] !== exp_mem[16'h601]) begin n_errors++; $display("FAIL abort_dst1: got %h, want %h", mem[16'h601], exp_mem[16'h601]); end
  endtask

  task automatic test_async_reset();
    int wcnt, nready;
    @(posedge clk); #1;
    cmd_src = 16'h700; cmd_dst = 16'h800; cmd_len = 16'd4; cmd_valid = 1'b1; mem_gnt = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL arst_busy_before: got %b, want 1", busy); end
    #1 reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL arst_busy: got %b, want 0", busy); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL arst_ready: got %b, want 1", cmd_ready); end
    n_checks++; if (remaining !== 16'h0) begin n_errors++; $display("FAIL arst_remaining: got %h, want 0000", remaining); end
    n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL arst_mem_req: got %b, want 0", mem_req); end
    n_checks++; if (dma_ADDR !== 16'h0) begin n_errors++; $display("FAIL arst_addr: got %h, want 0000", dma_ADDR); end
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    wcnt = 0; nready = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dma_WE) wcnt++;
      if (!cmd_ready) nready++;
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0;
    n_checks++; if (wcnt !== 0) begin n_errors++; $display("FAIL arst_stray_write: got %0d, want 0", wcnt); end
    n_checks++; if (nready !== 0) begin n_errors++; $display("FAIL arst_not_ready: got %0d, want 0", nready); end
    n_checks++; if (mem[16'h800] !== exp_mem[16'h800]) begin n_errors++; $display("FAIL arst_dst: got %h, want %h", mem[16'h800], exp_mem[16'h800]); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 16; t++) begin
      logic [15:0] s, d, rl;
      int n;
      s = 16'($urandom);
      d = ($urandom_range(0, 1) == 0) ? 16'(s + 16'($urandom_range(1, 4))) : 16'($urandom);
      n = $urandom_range(1, 8);
      ref_copy(s, d, n);
      run_cmd(s, d, 16'(n), 2, 0, 300);
      rl = (rem_q.size() > 0) ? rem_q[rem_q.size() - 1] : 16'hFFFF;
      n_checks++; if (done_cyc !== 3 * n + 1 + stall_cnt) begin n_errors++; $display("FAIL rnd%0d_done_cycle: got %0d, want %0d", t, done_cyc, 3 * n + 1 + stall_cnt); end
      n_checks++; if (idle_cyc !== done_cyc + 1) begin n_errors++; $display("FAIL rnd%0d_idle_cycle: got %0d, want %0d", t, idle_cyc, done_cyc + 1); end
      n_checks++; if (n_done !== 1) begin n_errors++; $display("FAIL rnd%0d_done_count: got %0d, want 1", t, n_done); end
      n_checks++; if (we_bad !== 0) begin n_errors++; $display("FAIL rnd%0d_we_without_gnt: got %0d, want 0", t, we_bad); end
      n_checks++; if (wr_q.size() !== n) begin n_errors++; $display("FAIL rnd%0d_write_count: got %0d, want %0d", t, wr_q.size(), n); end
      n_checks++; if (rl !== 16'h0) begin n_errors++; $display("FAIL rnd%0d_remaining: got %0d, want 0", t, rl); end
      for (int i = 0; i < n; i++) begin
        logic [15:0] ra, wa, da;
        logic [31:0] wd;
        da = 16'(d + i);
        ra = (rd_q.size() > i) ? rd_q[i] : 16'(s + i + 1);
        wa = (wr_q.size() > i) ? wr_q[i] : 16'(da + 1);
        wd = (wd_q.size() > i) ? wd_q[i] : ~exp_mem[da];
        n_checks++; if (ra !== 16'(s + i)) begin n_errors++; $display("FAIL rnd%0d_read_addr[%0d]: got %h, want %h", t, i, ra, 16'(s + i)); end
        n_checks++; if (wa !== da) begin n_errors++; $display("FAIL rnd%0d_write_addr[%0d]: got %h, want %h", t, i, wa, da); end
        n_checks++; if (wd !== exp_mem[da]) begin n_errors++; $display("FAIL rnd%0d_write_data[%0d]: got %h, want %h", t, i, wd, exp_mem[da]); end
        n_checks++; if (mem[da] !== exp_mem[da]) begin n_errors++; $display("FAIL rnd%0d_mem[%h]: got %h, want %h", t, da, mem[da], exp_mem[da]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) exp_mem[i] = seed_word(i);
    test_reset();
    test_basic_copy();
    test_zero_len();
    test_grant_stalls();
    test_address_wrap();
    test_abort_write();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
